// File: rtl/pipelined_csa_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 forms per-block speculative sums; stage 2 resolves carries by mux chain.
module pipelined_csa_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  // Upper-block storage keeps one dummy entry so NBLK=1 still elaborates
  localparam int unsigned NUP  = (NBLK > 1) ? NBLK - 1 : 1;

  logic                        s2_adv, s1_adv;
  logic [WIDTH-1:0]            bx;
  logic                        cx;

  logic [BLOCK-1:0]            blk0_sum_add;
  logic                        blk0_c_add;
  logic [NUP-1:0][BLOCK-1:0]   up_sum0_add, up_sum1_add;
  logic [NUP-1:0]              up_c0_add, up_c1_add;

  logic                        s1_valid_d, s1_valid_q;
  logic [BLOCK-1:0]            blk0_sum_d, blk0_sum_q;
  logic                        blk0_c_d, blk0_c_q;
  logic [NUP-1:0][BLOCK-1:0]   up_sum0_d, up_sum0_q, up_sum1_d, up_sum1_q;
  logic [NUP-1:0]              up_c0_d, up_c0_q, up_c1_d, up_c1_q;
  logic                        a_msb_d, a_msb_q, bx_msb_d, bx_msb_q;

  logic [WIDTH-1:0]            res_sum;
  logic                        res_c, res_ovf, chain_c;

  logic                        out_valid_d, out_valid_q;
  logic [WIDTH-1:0]            sum_d, sum_q;
  logic                        c_out_d, c_out_q, ovf_d, ovf_q;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    bx = sub ? ~b : b;
    cx = sub | c_in;
    {blk0_c_add, blk0_sum_add} = {1'b0, a[BLOCK-1:0]} + {1'b0, bx[BLOCK-1:0]}
                                 + {{BLOCK{1'b0}}, cx};
    up_sum0_add = '0;
    up_sum1_add = '0;
    up_c0_add   = '0;
    up_c1_add   = '0;
    for (int unsigned k = 1; k < NBLK; k++) begin
      {up_c0_add[k-1], up_sum0_add[k-1]} = {1'b0, a[k*BLOCK +: BLOCK]}
                                           + {1'b0, bx[k*BLOCK +: BLOCK]};
      {up_c1_add[k-1], up_sum1_add[k-1]} = {1'b0, a[k*BLOCK +: BLOCK]}
                                           + {1'b0, bx[k*BLOCK +: BLOCK]}
                                           + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    blk0_sum_d = blk0_sum_q;
    blk0_c_d   = blk0_c_q;
    up_sum0_d  = up_sum0_q;
    up_sum1_d  = up_sum1_q;
    up_c0_d    = up_c0_q;
    up_c1_d    = up_c1_q;
    a_msb_d    = a_msb_q;
    bx_msb_d   = bx_msb_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        blk0_sum_d = blk0_sum_add;
        blk0_c_d   = blk0_c_add;
        up_sum0_d  = up_sum0_add;
        up_sum1_d  = up_sum1_add;
        up_c0_d    = up_c0_add;
        up_c1_d    = up_c1_add;
        a_msb_d    = a[WIDTH-1];
        bx_msb_d   = bx[WIDTH-1];
      end
    end
  end

  // Carry resolution: each block picks its speculative pair from the carry below
  always_comb begin
    res_sum             = '0;
    res_sum[BLOCK-1:0]  = blk0_sum_q;
    chain_c             = blk0_c_q;
    for (int unsigned k = 1; k < NBLK; k++) begin
      if (chain_c) begin
        res_sum[k*BLOCK +: BLOCK] = up_sum1_q[k-1];
        chain_c                   = up_c1_q[k-1];
      end else begin
        res_sum[k*BLOCK +: BLOCK] = up_sum0_q[k-1];
        chain_c                   = up_c0_q[k-1];
      end
    end
    res_c   = chain_c;
    res_ovf = (a_msb_q == bx_msb_q) && (res_sum[WIDTH-1] != a_msb_q);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      sum_d       = res_sum;
      c_out_d     = res_c;
      ovf_d       = res_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      blk0_sum_q  <= '0;
      blk0_c_q    <= 1'b0;
      up_sum0_q   <= '0;
      up_sum1_q   <= '0;
      up_c0_q     <= '0;
      up_c1_q     <= '0;
      a_msb_q     <= 1'b0;
      bx_msb_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      blk0_sum_q  <= blk0_sum_d;
      blk0_c_q    <= blk0_c_d;
      up_sum0_q   <= up_sum0_d;
      up_sum1_q   <= up_sum1_d;
      up_c0_q     <= up_c0_d;
      up_c1_q     <= up_c1_d;
      a_msb_q     <= a_msb_d;
      bx_msb_q    <= bx_msb_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_csa_adder.md
Name: pipelined_csa_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor for the datapath. It generalises the fixed 64-bit carry-select adder in three ways:
- arbitrary WIDTH and carry-select BLOCK size;
- a subtract mode with a signed-overflow flag;
- a two-stage registered pipeline with valid/ready flow control, so it can sit between producers and consumers that stall.

Parameters:
WIDTH, 64, operand/result width in bits; must be an integer multiple of BLOCK.
BLOCK, 16, carry-select block width in bits; BLOCK >= 2. NBLK = WIDTH/BLOCK.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set on a/b/c_in/sub is valid
in_ready  output  1  adder accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry in; ignored when sub=1
sub  input  1  0: a+b+c_in; 1: a-b (a + ~b + 1)
out_valid  output  1  result on sum/c_out/ovf is valid
out_ready  input  1  consumer takes result this cycle
sum  output  WIDTH  result, modulo 2^WIDTH
c_out  output  1  carry out of MSB; when sub=1, 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, immediate): stage-1 valid=0, out_valid=0. sum, c_out and ovf reset to 0. Any operands in flight are discarded; no result is emitted for them after reset deasserts.
- Operand prep: bx = sub ? ~b : b; cx = sub ? 1 : c_in.
- Stage 1, on accept:
  - Block 0 (bits BLOCK-1:0) is added with cx directly; its sum and carry are registered.
  - Blocks 1..NBLK-1 each compute two ripple sums, one with carry-in 0 and one with carry-in 1. Both sums and both carry-outs are registered.
  - a[MSB] and bx[MSB] are registered for the overflow calculation.
- Stage 2:
  - Carries resolve left to right. Block k's sum and carry come from its carry-in-1 pair if block k-1's resolved carry=1, else from its carry-in-0 pair. This is a mux chain only; no adders in stage 2.
  - The resolved sum, the final block carry (c_out) and ovf are registered into the output register.
  - ovf = (a_msb == bx_msb) && (sum[WIDTH-1] != a_msb).
- Latency: exactly 2 cycles from accept (in_valid && in_ready) to out_valid with no stall. Throughput is 1 result per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. in_ready is combinational from out_ready; no reverse register.
  - On s2_adv, out_valid <= s1_valid and the output register loads stage 1.
  - On s1_adv, s1_valid <= in_valid and stage 1 loads if in_valid.
- Output hold: while out_valid && !out_ready, sum/c_out/ovf/out_valid are held stable. Stage 1 also holds if it is occupied.
- Ordering: results leave strictly in acceptance order. Nothing is dropped or duplicated. At most 2 results are in flight.
- Simultaneous events: with the pipe full and out_ready=1, in_valid=1, one result leaves, stage 1 moves forward and new operands are accepted, all in the same cycle.
- in_valid=0 while in_ready=1: stage 1 becomes empty (bubble). Its data registers may keep stale values.
- Degenerate case NBLK=1: stage 1 is a plain adder and stage 2 is a pass-through register; latency is still 2.

Test Plan (WIDTH=64, BLOCK=16, out_ready=1 unless stated):
- Wrap/carry: a=0xFFFFFFFFFFFFFFFF, b=0x1, c_in=0, sub=0 → 2 cycles later sum=0, c_out=1, ovf=0.
- Block boundary: a=0x000000000000FFFF, b=0x1 → sum=0x0000000000010000, c_out=0. Also a=0x0000FFFFFFFFFFFF, b=0, c_in=1 → sum=0x0001000000000000 (carry ripples through three selects).
- Subtract: a=5, b=7, sub=1, c_in=1 (ignored) → sum=0xFFFFFFFFFFFFFFFE, c_out=0, ovf=0. a=7, b=5 → sum=2, c_out=1.
- Signed overflow: a=0x7FFFFFFFFFFFFFFF, b=1 → sum=0x8000000000000000, ovf=1. a=0x8000000000000000, b=1, sub=1 → sum=0x7FFFFFFFFFFFFFFF, ovf=1, c_out=1.
- Backpressure: out_ready=0, drive 3 back-to-back inputs (1+1, 2+2, 3+3).
  - Expect 2 accepted, then in_ready=0 with third held; out_valid=1, sum=2 stable.
  - Raise out_ready: outputs 2, 4, 6 on consecutive cycles, in order, none lost.
- Reset mid-flight: accept 2 operand sets, assert rst before either emerges → out_valid=0 immediately (asynchronously), sum=0. After release, no stale result appears; a new 1+1 gives sum=2 after 2 cycles.
